// File: rtl/sm83_irq_ctl.sv
// rtl/sm83_irq_ctl.sv - SM83 interrupt controller with IF/IE registers and bus responder
//
// Purpose:
//   Latches rising edges on peripheral request lines into IF, masks them with
//   IE and presents the result to the core on irq. The core clears flags with
//   a one-hot (or multi-hot) iack. IF and IE are readable and writable over the
//   CPU bus; reads are registered with one cycle of latency.
//
// Optional build macro:
//   SM83_IRQ_SRC_SYNC_EN - when defined, src passes a 2-flop synchronizer
//   before edge detection (edge-to-IF latency 3 cycles instead of 1).
//
// Ports:
//   clk     core clock
//   nreset  synchronous active-low reset
//   adr     CPU address
//   din     CPU write data
//   dout    registered read data, valid while hit=1
//   hit     previous-cycle read addressed IF or IE
//   rd, wr  CPU read / write strobes
//   src     peripheral request levels, rising edge requests
//   irq     pending-and-enabled requests to the core
//   iack    acknowledge from the core, clears named IF bits
module sm83_irq_ctl #(
    parameter int unsigned NUM_SRC = 5,
    parameter logic [15:0] IF_ADR  = 16'hff0f,
    parameter logic [15:0] IE_ADR  = 16'hffff
) (
    input  logic               clk,
    input  logic               nreset,
    input  logic [15:0]        adr,
    input  logic [7:0]         din,
    output logic [7:0]         dout,
    output logic               hit,
    input  logic               rd,
    input  logic               wr,
    input  logic [NUM_SRC-1:0] src,
    output logic [7:0]         irq,
    input  logic [7:0]         iack
);

    logic [NUM_SRC-1:0] r_if;
    logic [NUM_SRC-1:0] r_src_q;
    logic [7:0]         r_ie;
    logic [7:0]         r_dout;
    logic               r_hit;

    logic [NUM_SRC-1:0] w_src_e;
    logic [NUM_SRC-1:0] w_rise;
    logic [NUM_SRC-1:0] w_if_base;
    logic [7:0]         w_if_rd;
    logic [7:0]         w_irq;
    logic               w_if_sel;
    logic               w_ie_sel;
    logic               w_unused_iack;

    assign w_if_sel = (adr == IF_ADR);
    assign w_ie_sel = (adr == IE_ADR);

    // iack bits above NUM_SRC have no flag to clear.
    assign w_unused_iack = ^iack;

`ifdef SM83_IRQ_SRC_SYNC_EN
    logic [NUM_SRC-1:0] r_sync1;
    logic [NUM_SRC-1:0] r_sync2;

    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= src;
            r_sync2 <= r_sync1;
        end
    end

    assign w_src_e = r_sync2;

    // History cleared to 0 so a source held high through reset requests once
    // after it has propagated through the synchronizer.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_src_q <= '0;
        end else begin
            r_src_q <= w_src_e;
        end
    end
`else
    assign w_src_e = src;

    // History tracks src even during reset, so a line already high at reset
    // release is not treated as a new request.
    always_ff @(posedge clk) begin
        r_src_q <= w_src_e;
    end
`endif

    assign w_rise = w_src_e & ~r_src_q;

    // Unimplemented IF bits read as 1.
    always_comb begin
        w_if_rd                = 8'hff;
        w_if_rd[NUM_SRC-1:0]   = r_if;
    end

    always_comb begin
        w_irq                  = 8'h00;
        w_irq[NUM_SRC-1:0]     = r_if & r_ie[NUM_SRC-1:0];
    end

    // Edge set wins over ack clear, which wins over CPU write.
    assign w_if_base = (wr && w_if_sel) ? din[NUM_SRC-1:0] : r_if;

    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_if   <= '0;
            r_ie   <= 8'h00;
            r_dout <= 8'h00;
            r_hit  <= 1'b0;
        end else begin
            r_if <= (w_if_base & ~iack[NUM_SRC-1:0]) | w_rise;
            if (wr && w_ie_sel) begin
                r_ie <= din;
            end
            // Reads sample the pre-update register values.
            if (rd && w_if_sel) begin
                r_dout <= w_if_rd;
                r_hit  <= 1'b1;
            end else if (rd && w_ie_sel) begin
                r_dout <= r_ie;
                r_hit  <= 1'b1;
            end else begin
                r_hit  <= 1'b0;
            end
        end
    end

    assign dout = r_dout;
    assign hit  = r_hit;
    assign irq  = w_irq;

endmodule
